ps2_rx_fifo: RTL
================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver. It synchronises and deglitches ps2_clock, decodes 11-bit frames (start, 8 data LSB first, odd parity, stop) and detects parity, framing and timeout errors. Good scan codes are buffered in a first-word-fall-through FIFO with a valid/ready handshake. It sits between the PS/2 pins and the keyboard/scan-code consumer logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages on ps2_clock and ps2_data (min 2)
FILTER_LEN, 8, consecutive equal synced samples needed before the filtered clock changes (min 1)
TIMEOUT_CYCLES, 5000, clk cycles allowed between falling edges inside a frame before abort (100 us at 50 MHz)
FIFO_DEPTH, 16, scan-code entries; power of 2, min 2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ps2_clock  in  1  raw PS/2 clock pin (asynchronous)
ps2_data  in  1  raw PS/2 data pin (asynchronous)
code_valid  out  1  FIFO non-empty; code_data holds oldest code
code_ready  in  1  consumer accepts code_data when code_valid & code_ready
code_data  out  8  head-of-FIFO scan code
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
busy  out  1  frame in progress (state != IDLE)
parity_err  out  1  one-cycle pulse: frame dropped, parity bad
framing_err  out  1  one-cycle pulse: frame dropped, stop bit 0
timeout_err  out  1  one-cycle pulse: frame aborted by timeout
overflow  out  1  one-cycle pulse: good frame dropped, FIFO full

Behaviour:
- Reset (async assert, sync deassert by design): all outputs 0; synchroniser and filtered clock regs preset to 1 (idle bus); state IDLE; FIFO empty.
- Filter: the filtered clock takes the synced value only after FILTER_LEN consecutive cycles of a value differing from it. Shorter glitches are ignored. fall = filtered 1->0 for one cycle.
- ps2_data is sampled from its synchroniser output in the fall cycle.
- FSM:
  - IDLE: on fall, data 0 -> DATA, bit_cnt=0; data 1 -> stay IDLE, no error.
  - DATA: on fall, shift[bit_cnt]=data; at bit_cnt==7 -> PARITY, else bit_cnt+1.
  - PARITY: on fall, store bit -> STOP.
  - STOP: on fall -> IDLE, then classify:
    - data==0 -> framing_err (takes priority over parity).
    - else XOR of 8 data bits and parity bit ==0 -> parity_err.
    - else push if FIFO not full; if full -> overflow, code dropped.
- Timeout: counter clears on every fall and while IDLE; otherwise increments. When it reaches TIMEOUT_CYCLES-1 -> timeout_err pulse, partial frame discarded, -> IDLE. A fall in that same cycle is ignored.
- Latency: code_valid/code_data reflect a push on the cycle after the stop-bit fall cycle.
- FIFO: first-word-fall-through. Pop = code_valid & code_ready.
  - Simultaneous push and pop: both occur, count unchanged, including when full (no overflow).
  - Pop when empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
  - code_data holds its last value when empty (not specified for checking).
- At most one error pulse per frame. The FIFO is unaffected by any error.

Decomposition:
- Package ps2_pkg holds:
  - state enum {IDLE, DATA, PARITY, STOP}
  - constants PS2_DATA_BITS=8, PS2_START_BIT=1'b0, PS2_STOP_BIT=1'b1
- One sub-module, ps2_code_fifo (parametrised WIDTH/DEPTH, FWFT, count output). It is reused later by the PS/2 transmit path.
- Synchroniser and filter stay inline.

Test Plan:
- Frame 0x1C (data bits 0,0,1,1,1,0,0,0; parity 0; stop 1), code_ready=0 -> code_valid=1, code_data=0x1C, fifo_count=1, no error pulses. Then code_ready=1 for one cycle -> fifo_count=0.
- Frame 0xF0 with parity 0 (should be 1) -> parity_err pulse once, fifo_count unchanged. Same frame with stop=0 -> framing_err only.
- 3-cycle low glitch on ps2_clock, FILTER_LEN=8, mid-frame -> no bit advance; the following complete frame 0x1C decodes correctly.
- Start bit plus 4 data bits, then idle TIMEOUT_CYCLES -> timeout_err pulse, busy=0. Next full frame 0x32 -> code_data=0x32.
- 17 frames 0x01..0x11 with code_ready=0 -> fifo_count=16, one overflow pulse on the 17th. Draining yields 0x01..0x10 in order.
- reset_n low for 1 cycle mid-frame after 5 bits -> busy=0, fifo_count=0, outputs 0. Next frame 0x5A received intact.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 types and frame constants for the receive (and later transmit) paths.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int   PS2_DATA_BITS = 8;
    localparam logic PS2_START_BIT = 1'b0;
    localparam logic PS2_STOP_BIT  = 1'b1;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// First-word-fall-through FIFO with occupancy count; head word is a registered RAM read.
module ps2_code_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       valid,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] data_reg;
    logic             do_push;
    logic             do_pop;

    assign valid     = (count_reg != '0);
    assign full      = (count_reg == DEPTH_C);
    assign head_data = data_reg;
    assign count     = count_reg;

    assign do_pop      = pop & valid;
    assign do_push     = push & (~full | do_pop);
    assign rd_ptr_next = rd_ptr_reg + AW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // The head register reads the slot that will be oldest next cycle; a write to that
    // same slot this cycle is forwarded so a push into an emptying FIFO falls through.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            data_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            if (do_push && !do_pop) begin
                count_reg <= count_reg + ONE_C;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - ONE_C;
            end
            if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
                data_reg <= push_data;
            end else begin
                data_reg <= mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchroniser, clock deglitch filter, frame decoder
// with parity/framing/timeout checks, and a scan-code FIFO toward the consumer.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ps2_clock,
    input  logic                          ps2_data,
    output logic                          code_valid,
    input  logic                          code_ready,
    output logic [7:0]                    code_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          parity_err,
    output logic                          framing_err,
    output logic                          timeout_err,
    output logic                          overflow
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int BW = $clog2(PS2_DATA_BITS);
    localparam logic [FW-1:0] FILTER_LAST  = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT     = BW'(PS2_DATA_BITS - 1);

    logic [SYNC_STAGES-1:0]   clk_sync_reg;
    logic [SYNC_STAGES-1:0]   data_sync_reg;
    logic                     clk_synced;
    logic                     data_synced;
    logic [FW-1:0]            filt_cnt_reg;
    logic                     filt_clk_reg;
    logic                     filt_prev_reg;
    logic                     fall;
    logic [TW-1:0]            to_cnt_reg;
    logic                     timeout_hit;

    ps2_state_t               state_reg, state_next;
    logic [BW-1:0]            bit_cnt_reg, bit_cnt_next;
    logic [PS2_DATA_BITS-1:0] shift_reg, shift_next;
    logic                     parity_reg, parity_next;
    logic                     push_next;
    logic                     perr_next, ferr_next, terr_next, ovf_next;
    logic                     parity_err_reg, framing_err_reg, timeout_err_reg, overflow_reg;

    logic                     fifo_pop;
    logic                     fifo_full;

    assign clk_synced  = clk_sync_reg[SYNC_STAGES-1];
    assign data_synced = data_sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clock};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // The filtered clock only follows after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_cnt_reg  <= '0;
            filt_clk_reg  <= 1'b1;
            filt_prev_reg <= 1'b1;
        end else begin
            filt_prev_reg <= filt_clk_reg;
            if (clk_synced == filt_clk_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == FILTER_LAST) begin
                filt_clk_reg <= clk_synced;
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + FW'(1);
            end
        end
    end

    assign fall        = filt_prev_reg & ~filt_clk_reg;
    assign timeout_hit = (state_reg != IDLE) && (to_cnt_reg == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_reg <= '0;
        end else if (state_reg == IDLE || fall || timeout_hit) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + TW'(1);
        end
    end

    assign fifo_pop = code_valid & code_ready;

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        push_next    = 1'b0;
        perr_next    = 1'b0;
        ferr_next    = 1'b0;
        terr_next    = 1'b0;
        ovf_next     = 1'b0;
        // Timeout wins over a coincident fall, so a late edge cannot revive a dead frame.
        if (timeout_hit) begin
            state_next = IDLE;
            terr_next  = 1'b1;
        end else if (fall) begin
            case (state_reg)
                IDLE: begin
                    if (data_synced == PS2_START_BIT) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    shift_next[bit_cnt_reg] = data_synced;
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next = PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BW'(1);
                    end
                end
                PARITY: begin
                    parity_next = data_synced;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (data_synced != PS2_STOP_BIT) begin
                        ferr_next = 1'b1;
                    end else if (!odd_parity_ok(shift_reg, parity_reg)) begin
                        perr_next = 1'b1;
                    end else if (fifo_full && !fifo_pop) begin
                        ovf_next = 1'b1;
                    end else begin
                        push_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            parity_reg      <= 1'b0;
            parity_err_reg  <= 1'b0;
            framing_err_reg <= 1'b0;
            timeout_err_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            parity_reg      <= parity_next;
            parity_err_reg  <= perr_next;
            framing_err_reg <= ferr_next;
            timeout_err_reg <= terr_next;
            overflow_reg    <= ovf_next;
        end
    end

    assign busy        = (state_reg != IDLE);
    assign parity_err  = parity_err_reg;
    assign framing_err = framing_err_reg;
    assign timeout_err = timeout_err_reg;
    assign overflow    = overflow_reg;

    ps2_code_fifo #(
        .WIDTH (PS2_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_next),
        .push_data (shift_reg),
        .pop       (fifo_pop),
        .valid     (code_valid),
        .head_data (code_data),
        .count     (fifo_count),
        .full      (fifo_full)
    );

endmodule
